// File: rtl/vga_rect_compositor_pkg.sv
// Shared VGA constants and the packed {R,G,B} pixel type used by the
// rectangle compositor and the sync generator.
package vga_rect_compositor_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam int COLOR_W = $bits(rgb_t);

endpackage

// File: rtl/vga_rect_compositor_rect_hit_test.sv
// Combinational point-in-rectangle test for one rectangle. The far edges are
// computed one bit wider so that a rectangle near the top of the coordinate
// range cannot wrap.
module rect_hit_test #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  logic               vis,
  output logic               hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, rx} + {1'b0, w};
  assign y_end = {1'b0, ry} + {1'b0, h};

  // A zero width or height gives an empty half-open interval, so it never hits.
  assign hit = vis
             && (x >= rx) && ({1'b0, x} < x_end)
             && (y >= ry) && ({1'b0, y} < y_end);

endmodule

// File: rtl/vga_rect_compositor.sv
// N-rectangle priority compositor. It holds shadow/active rectangle registers,
// a 2-stage pixel pipeline and a per-frame collision accumulator.
module vga_rect_compositor
  import vga_rect_compositor_pkg::*;
#(
  parameter int                 N_RECT   = 4,
  parameter int                 COORD_W  = 10,
  parameter int                 H_ACTIVE = VGA_H_ACTIVE,
  parameter int                 V_ACTIVE = VGA_V_ACTIVE,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  localparam int                IDX_W    = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_hSync,
  input  logic               i_vSync,
  input  logic [COORD_W-1:0] i_x_pos,
  input  logic [COORD_W-1:0] i_y_pos,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [COORD_W-1:0] i_wr_x,
  input  logic [COORD_W-1:0] i_wr_y,
  input  logic [COORD_W-1:0] i_wr_w,
  input  logic [COORD_W-1:0] i_wr_h,
  input  logic [COLOR_W-1:0] i_wr_color,
  input  logic               i_wr_vis,
  output logic [2:0]         o_red,
  output logic [2:0]         o_green,
  output logic [2:0]         o_blue,
  output logic               o_hSync,
  output logic               o_vSync,
  output logic               o_frame_tick,
  output logic [N_RECT-1:0]  o_collide
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    rgb_t               color;
    logic               vis;
  } rect_t;

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);
  localparam logic [IDX_W:0]     N_LIM = (IDX_W + 1)'(N_RECT);

  rect_t shadow_q [N_RECT];
  rect_t shadow_d [N_RECT];
  rect_t active_q [N_RECT];
  rect_t active_d [N_RECT];

  logic [N_RECT-1:0] hit_s0;
  logic              area_s0;
  logic              commit;
  logic              wr_idx_ok;
  logic              multi_hit;

  logic [N_RECT-1:0] hit_s1_q, hit_s1_d;
  logic              area_s1_q, area_s1_d;
  logic              hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  rgb_t              rgb_q, rgb_d;
  logic              hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic              tick_q, tick_d;
  logic [N_RECT-1:0] acc_q, acc_d;
  logic [N_RECT-1:0] collide_q, collide_d;

  for (genvar k = 0; k < N_RECT; k++) begin : g_hit
    rect_hit_test #(.COORD_W(COORD_W)) u_hit (
      .x   (i_x_pos),
      .y   (i_y_pos),
      .rx  (active_q[k].x),
      .ry  (active_q[k].y),
      .w   (active_q[k].w),
      .h   (active_q[k].h),
      .vis (active_q[k].vis),
      .hit (hit_s0[k])
    );
  end

  assign area_s0   = (i_x_pos < H_LIM) && (i_y_pos < V_LIM);
  assign commit    = (i_x_pos == '0) && (i_y_pos == V_LIM);
  assign wr_idx_ok = {1'b0, i_wr_idx} < N_LIM;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = |(hit_s0 & (hit_s0 - N_RECT'(1)));

  // Shadow/active register banks; a write in the commit cycle reaches shadow only.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit) active_d = shadow_q;
    if (i_wr_en && wr_idx_ok) begin
      shadow_d[i_wr_idx] = '{x: i_wr_x, y: i_wr_y, w: i_wr_w, h: i_wr_h,
                             color: rgb_t'(i_wr_color), vis: i_wr_vis};
    end
  end

  always_comb begin
    hit_s1_d  = hit_s0;
    area_s1_d = area_s0;
    hs_s1_d   = i_hSync;
    vs_s1_d   = i_vSync;
    hs_s2_d   = hs_s1_q;
    vs_s2_d   = vs_s1_q;
    tick_d    = commit;
    acc_d     = acc_q | ((area_s0 && multi_hit) ? hit_s0 : '0);
    collide_d = collide_q;
    if (commit) begin
      collide_d = acc_q;
      acc_d     = '0;
    end
    // Walk from the lowest priority upward so index 0 wins.
    rgb_d = rgb_t'(BG_COLOR);
    for (int k = N_RECT - 1; k >= 0; k--) begin
      if (hit_s1_q[k]) rgb_d = active_q[k].color;
    end
    if (!area_s1_q) rgb_d = '0;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      // NOTE: the rectangle banks are reset element by element; leaving them
      // unreset would let garbage rectangles show before the first write.
      for (int k = 0; k < N_RECT; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      hit_s1_q  <= '0;
      area_s1_q <= 1'b0;
      hs_s1_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      rgb_q     <= '0;
      hs_s2_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      tick_q    <= 1'b0;
      acc_q     <= '0;
      collide_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      hit_s1_q  <= hit_s1_d;
      area_s1_q <= area_s1_d;
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      rgb_q     <= rgb_d;
      hs_s2_q   <= hs_s2_d;
      vs_s2_q   <= vs_s2_d;
      tick_q    <= tick_d;
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign o_red        = rgb_q.r;
  assign o_green      = rgb_q.g;
  assign o_blue       = rgb_q.b;
  assign o_hSync      = hs_s2_q;
  assign o_vSync      = vs_s2_q;
  assign o_frame_tick = tick_q;
  assign o_collide    = collide_q;

endmodule

// File: tb/tb_vga_rect_compositor.sv
// Scoreboard bench for vga_rect_compositor: a rectangle model predicts each
// driven pixel, and the prediction is compared two clocks later.
module tb_vga_rect_compositor;

  localparam int          N   = 3;
  localparam int          CW  = 10;
  localparam int          IW  = 2;
  localparam int          HA  = 640;
  localparam int          VA  = 480;
  localparam logic [8:0]  BG  = 9'h049;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hs_in = 1'b1, vs_in = 1'b1;
  logic [CW-1:0] x_pos = '0, y_pos = '0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [CW-1:0] wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
  logic [8:0]    wr_color = '0;
  logic          wr_vis = 1'b0;
  logic [2:0]    o_red, o_green, o_blue;
  logic          o_hSync, o_vSync, o_frame_tick;
  logic [N-1:0]  o_collide;

  vga_rect_compositor #(
    .N_RECT(N), .COORD_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .BG_COLOR(BG)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_hSync(hs_in), .i_vSync(vs_in),
    .i_x_pos(x_pos), .i_y_pos(y_pos), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
    .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_w(wr_w), .i_wr_h(wr_h),
    .i_wr_color(wr_color), .i_wr_vis(wr_vis),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_hSync(o_hSync), .o_vSync(o_vSync), .o_frame_tick(o_frame_tick),
    .o_collide(o_collide)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] rgb; logic hs; logic vs; } px_t;
  typedef struct { int x; int y; int w; int h; logic [8:0] c; bit v; } mrect_t;

  px_t          exp_q[$];
  mrect_t       m_sh[N];
  mrect_t       m_act[N];
  logic [N-1:0] m_acc = '0;
  logic [N-1:0] m_collide = '0;
  logic         m_tick = 1'b0;
  int           vec_cnt = 0;
  int           err_cnt = 0;

  function automatic bit m_hit(input mrect_t r, input int x, input int y);
    return r.v && r.w > 0 && r.h > 0 && x >= r.x && x < r.x + r.w
           && y >= r.y && y < r.y + r.h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_sh[k]  = '{0, 0, 0, 0, 9'h000, 1'b0};
      m_act[k] = '{0, 0, 0, 0, 9'h000, 1'b0};
    end
    m_acc = '0; m_collide = '0; m_tick = 1'b0;
    exp_q.delete();
  endtask

  // One pixel clock: drive, predict, clock, then check the pixel driven one call earlier.
  task automatic cycle(input int x, input int y);
    px_t          e, got;
    logic [N-1:0] hv;
    bit           area;
    x_pos = CW'(x); y_pos = CW'(y);
    hs_in = 1'($urandom_range(0, 1)); vs_in = 1'($urandom_range(0, 1));
    area = (x < HA) && (y < VA);
    hv = '0;
    for (int k = 0; k < N; k++) hv[k] = m_hit(m_act[k], x, y);
    e.rgb = area ? BG : 9'h000;
    if (area) for (int k = N - 1; k >= 0; k--) if (hv[k]) e.rgb = m_act[k].c;
    e.hs = hs_in; e.vs = vs_in;
    exp_q.push_back(e);
    if (area && $countones(hv) >= 2) m_acc = m_acc | hv;
    m_tick = (x == 0) && (y == VA);
    if (m_tick) begin
      for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
      m_collide = m_acc;
      m_acc = '0;
    end
    if (wr_en && int'(wr_idx) < N)
      m_sh[wr_idx] = '{int'(wr_x), int'(wr_y), int'(wr_w), int'(wr_h), wr_color, wr_vis};
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      got = {o_red, o_green, o_blue, o_hSync, o_vSync};
      vec_cnt++;
      if (got !== e) begin
        err_cnt++;
        $display("FAIL pixel_path: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                 got.rgb, got.hs, got.vs, e.rgb, e.hs, e.vs);
      end
    end
    vec_cnt++;
    if (o_frame_tick !== m_tick) begin
      err_cnt++;
      $display("FAIL frame_tick at (%0d,%0d): got %b want %b", x, y, o_frame_tick, m_tick);
    end
    vec_cnt++;
    if (o_collide !== m_collide) begin
      err_cnt++;
      $display("FAIL collide_track: got %b want %b", o_collide, m_collide);
    end
  endtask

  task automatic flush();
    cycle(700, 500);
    cycle(700, 500);
  endtask

  task automatic commit();
    cycle(0, VA);
    flush();
  endtask

  task automatic write_rect(input int idx, input int x, input int y, input int w,
                            input int h, input logic [8:0] c, input bit v);
    wr_en = 1'b1; wr_idx = IW'(idx);
    wr_x = CW'(x); wr_y = CW'(y); wr_w = CW'(w); wr_h = CW'(h);
    wr_color = c; wr_vis = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [13:0] got;
    got = {o_red, o_green, o_blue, o_hSync, o_vSync, o_frame_tick};
    vec_cnt++;
    if (got !== {9'h000, 1'b1, 1'b1, 1'b0} || o_collide !== '0) begin
      err_cnt++;
      $display("FAIL %s: got rgb/hs/vs/tick=%h collide=%b, want %h collide=0",
               tag, got, o_collide, {9'h000, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_empty_frame();
    int pts[10][2] = '{'{0, 0}, '{639, 0}, '{0, 479}, '{639, 479}, '{320, 240},
                       '{640, 0}, '{700, 300}, '{10, 480}, '{10, 520}, '{1023, 1023}};
    for (int i = 0; i < 10; i++) cycle(pts[i][0], pts[i][1]);
    commit();
  endtask

  task automatic scan_red_box();
    int xs[4] = '{9, 10, 24, 25};
    int ys[4] = '{99, 100, 179, 180};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) cycle(xs[i], ys[j]);
  endtask

  task automatic test_single_rect();
    write_rect(0, 10, 100, 15, 80, 9'h1C0, 1'b1);
    cycle(700, 10);
    scan_red_box();
    commit();
    scan_red_box();
    flush();
  endtask

  task automatic test_overlap();
    write_rect(0, 100, 100, 20, 20, 9'h007, 1'b1);
    cycle(700, 10);
    write_rect(1, 110, 110, 20, 20, 9'h038, 1'b1);
    cycle(700, 10);
    commit();
    cycle(105, 105); cycle(115, 115); cycle(119, 119); cycle(120, 120);
    cycle(125, 125); cycle(129, 129); cycle(130, 130);
    commit();
    vec_cnt++;
    if (o_collide !== 3'b011) begin
      err_cnt++;
      $display("FAIL overlap_collide: got %b want 011", o_collide);
    end
  endtask

  task automatic test_commit_write();
    write_rect(2, 300, 300, 10, 10, 9'h1F8, 1'b1);
    cycle(0, VA);
    flush();
    cycle(305, 305); cycle(300, 300);
    commit();
    cycle(305, 305); cycle(309, 309); cycle(310, 310);
    flush();
  endtask

  task automatic test_clip();
    write_rect(2, 630, 470, 50, 50, 9'h0F0, 1'b1);
    cycle(700, 10);
    write_rect(1, 660, 470, 20, 10, 9'h038, 1'b1);
    cycle(700, 10);
    write_rect(N, 0, 0, 20, 20, 9'h1FF, 1'b1);
    cycle(700, 10);
    commit();
    cycle(629, 469); cycle(630, 470); cycle(639, 479); cycle(640, 479);
    cycle(639, 480); cycle(665, 475); cycle(0, 0); cycle(5, 5); cycle(0, 470);
    commit();
    vec_cnt++;
    if (o_collide !== '0) begin
      err_cnt++;
      $display("FAIL offscreen_collide: got %b want 000", o_collide);
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle(105, 105); cycle(635, 475); cycle(106, 106);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_async");
    @(posedge clk); #1 check_reset_outputs("midframe_held");
    model_reset();
    #2 rst_n = 1'b1;
    cycle(105, 105); cycle(635, 475);
    write_rect(0, 10, 10, 5, 5, 9'h1C0, 1'b1);
    cycle(12, 12); cycle(12, 12);
    commit();
    cycle(12, 12); cycle(105, 105); cycle(15, 15);
    flush();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_empty_frame();
    test_single_rect();
    test_overlap();
    test_commit_write();
    test_clip();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
